// File: rtl/alu_seq_if.sv
// Operand/result bundle between the operand muxes, alu_seq and the control unit.
// The master drives operands and the request; the slave returns result, flags and status.
interface alu_seq_if;
  logic [7:0] a_i;
  logic [7:0] b_i;
  logic [3:0] op_i;
  logic       valid_i;
  logic       ready_o;
  logic [7:0] result_o;
  logic [7:0] result_hi_o;
  logic [3:0] flags_o;
  logic       valid_o;
  logic       busy_o;

  modport master (
    output a_i, b_i, op_i, valid_i,
    input  ready_o, result_o, result_hi_o, flags_o, valid_o, busy_o
  );

  modport slave (
    input  a_i, b_i, op_i, valid_i,
    output ready_o, result_o, result_hi_o, flags_o, valid_o, busy_o
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential 8-bit ALU with a persistent {Z,N,C,V} status register.
// Define ALU_MUL_EN to build the 9-cycle iterative 8x8 multiplier (opcode 8).
module alu_seq (
  input logic      clk_i,
  input logic      rst_i,
  alu_seq_if.slave bus
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'd8;
`endif

`ifdef ALU_MUL_EN
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;
`else
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0
  } state_t;
`endif

  state_t     state_r;
  logic [7:0] result_r;
  logic [7:0] result_hi_r;
  logic [3:0] flags_r;
  logic       valid_r;
  logic       busy_r;
  logic       ready_s;
  logic       accept_s;

  logic [8:0] sum_s;
  logic [8:0] diff_s;
  logic [7:0] alu_res_s;
  logic       alu_c_s;
  logic       alu_v_s;

`ifdef ALU_MUL_EN
  logic [7:0]  mcand_r;
  logic [7:0]  mplier_r;
  logic [15:0] acc_r;
  logic [2:0]  cnt_r;
  logic [15:0] acc_next_s;
`endif

  function automatic logic [3:0] pack_flags(input logic [7:0] res,
                                            input logic       c,
                                            input logic       v);
    return {(res == 8'h00), res[7], c, v};
  endfunction

  function automatic logic add_ovf(input logic [7:0] a, input logic [7:0] b,
                                   input logic [7:0] r);
    return (a[7] == b[7]) && (r[7] != a[7]);
  endfunction

  function automatic logic sub_ovf(input logic [7:0] a, input logic [7:0] b,
                                   input logic [7:0] r);
    return (a[7] != b[7]) && (r[7] != a[7]);
  endfunction

  // ready depends only on state and reset, never on valid_i
`ifdef ALU_MUL_EN
  assign ready_s = !rst_i && (state_r == ST_IDLE);
`else
  assign ready_s = !rst_i;
`endif
  assign accept_s = bus.valid_i && ready_s;

  assign sum_s  = {1'b0, bus.a_i} + {1'b0, bus.b_i};
  assign diff_s = {1'b0, bus.a_i} - {1'b0, bus.b_i};

  // Single-cycle result and carry/overflow selection
  always_comb begin
    alu_res_s = bus.a_i;
    alu_c_s   = 1'b0;
    alu_v_s   = 1'b0;
    case (bus.op_i)
      OP_ADD: begin
        alu_res_s = sum_s[7:0];
        alu_c_s   = sum_s[8];
        alu_v_s   = add_ovf(bus.a_i, bus.b_i, sum_s[7:0]);
      end
      OP_SUB: begin
        alu_res_s = diff_s[7:0];
        alu_c_s   = diff_s[8];
        alu_v_s   = sub_ovf(bus.a_i, bus.b_i, diff_s[7:0]);
      end
      OP_AND: alu_res_s = bus.a_i & bus.b_i;
      OP_OR:  alu_res_s = bus.a_i | bus.b_i;
      OP_XOR: alu_res_s = bus.a_i ^ bus.b_i;
      OP_NOT: alu_res_s = ~bus.a_i;
      OP_SHL: begin
        alu_res_s = {bus.a_i[6:0], 1'b0};
        alu_c_s   = bus.a_i[7];
      end
      OP_SHR: begin
        alu_res_s = {1'b0, bus.a_i[7:1]};
        alu_c_s   = bus.a_i[0];
      end
      default: begin
        alu_res_s = bus.a_i;
        alu_c_s   = 1'b0;
        alu_v_s   = 1'b0;
      end
    endcase
  end

`ifdef ALU_MUL_EN
  // One shift-add step on multiplier bit [cnt_r]
  always_comb begin
    acc_next_s = acc_r;
    if (mplier_r[cnt_r]) begin
      acc_next_s = acc_r + ({8'h00, mcand_r} << cnt_r);
    end else begin
      acc_next_s = acc_r;
    end
  end
`endif

  // Control FSM with registered result, status and handshake outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= ST_IDLE;
      result_r    <= 8'h00;
      result_hi_r <= 8'h00;
      flags_r     <= 4'b0000;
      valid_r     <= 1'b0;
      busy_r      <= 1'b0;
`ifdef ALU_MUL_EN
      mcand_r     <= 8'h00;
      mplier_r    <= 8'h00;
      acc_r       <= 16'h0000;
      cnt_r       <= 3'd0;
`endif
    end else begin
      valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
`ifdef ALU_MUL_EN
            if (bus.op_i == OP_MUL) begin
              mcand_r  <= bus.a_i;
              mplier_r <= bus.b_i;
              acc_r    <= 16'h0000;
              cnt_r    <= 3'd0;
              busy_r   <= 1'b1;
              state_r  <= ST_MUL;
            end else begin
              result_r    <= alu_res_s;
              result_hi_r <= 8'h00;
              flags_r     <= pack_flags(alu_res_s, alu_c_s, alu_v_s);
              valid_r     <= 1'b1;
            end
`else
            result_r    <= alu_res_s;
            result_hi_r <= 8'h00;
            flags_r     <= pack_flags(alu_res_s, alu_c_s, alu_v_s);
            valid_r     <= 1'b1;
`endif
          end
        end
`ifdef ALU_MUL_EN
        ST_MUL: begin
          acc_r <= acc_next_s;
          if (cnt_r == 3'd7) begin
            result_r    <= acc_next_s[7:0];
            result_hi_r <= acc_next_s[15:8];
            flags_r     <= pack_flags(acc_next_s[7:0], (acc_next_s[15:8] != 8'h00), 1'b0);
            valid_r     <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r + 3'd1;
          end
        end
`endif
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready_o     = ready_s;
  assign bus.result_o    = result_r;
  assign bus.result_hi_o = result_hi_r;
  assign bus.flags_o     = flags_r;
  assign bus.valid_o     = valid_r;
  assign bus.busy_o      = busy_r;

endmodule
